// File: rtl/vector_word_packer.sv
// vector_word_packer
// Collects lane-tagged 64-bit words into a 512-bit line and hands completed
// lines downstream through a registered valid/ready output stage. A line
// completes when every lane has been written or when a word carries in_last.
// LANES must equal 2**SEL_W so that every in_select value names a real lane.

module vector_word_packer #(
    parameter int WORD_W = 64,
    parameter int LANES  = 8,
    parameter int SEL_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_select,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W*LANES-1:0]   out_data,
    output logic [LANES-1:0]          out_mask,
    output logic [SEL_W:0]            out_count
);

    localparam int LINE_W = WORD_W * LANES;

    logic [LINE_W-1:0] acc_data;
    logic [LANES-1:0]  acc_mask;

    logic [LINE_W-1:0] merged_data;
    logic [LANES-1:0]  merged_mask;
    logic [SEL_W:0]    merged_count;
    logic              accept;
    logic              complete;

    // Input side may proceed whenever the output register is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Apply the incoming word to a copy of the accumulation buffer.
    always_comb begin
        merged_data = acc_data;
        for (int i = 0; i < LANES; i++) begin
            if (in_select == SEL_W'(i)) begin
                merged_data[i*WORD_W +: WORD_W] = in_data;
            end
        end
        merged_mask = acc_mask | (LANES'(1) << in_select);
    end

    // Population count of the merged mask; repeated lane writes count once.
    always_comb begin
        merged_count = '0;
        for (int i = 0; i < LANES; i++) begin
            merged_count = merged_count + {{SEL_W{1'b0}}, merged_mask[i]};
        end
    end

    assign complete = accept && ((merged_mask == {LANES{1'b1}}) || in_last);

    // Accumulation buffer: absorb accepted words, clear when a line closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data <= '0;
            acc_mask <= '0;
        end else if (accept) begin
            if (complete) begin
                acc_data <= '0;
                acc_mask <= '0;
            end else begin
                acc_data <= merged_data;
                acc_mask <= merged_mask;
            end
        end
    end

    // Output register: load on completion, otherwise drop valid once taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
            out_count <= '0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_data  <= merged_data;
            out_mask  <= merged_mask;
            out_count <= merged_count;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vector_word_packer.sv
// Directed testbench for vector_word_packer: each task drives one scenario
// and compares the outputs against hand-computed expected values.

module tb_vector_word_packer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [2:0]   in_select;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic [7:0]   out_mask;
    logic [3:0]   out_count;

    int checks;
    int failures;
    int line_count;

    vector_word_packer #(
        .WORD_W(64),
        .LANES (8),
        .SEL_W (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_select(in_select),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_mask (out_mask),
        .out_count(out_count)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count delivered lines mid-cycle, when handshake signals are stable.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) line_count++;
    end

    // Offer one word for a single cycle and leave the bench 1 unit past the edge.
    task automatic drive_word(input logic [2:0] sel, input logic [63:0] data, input logic last);
        in_valid  = 1'b1;
        in_select = sel;
        in_data   = data;
        in_last   = last;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 512'd0) begin failures++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
        checks++;
        if (out_mask !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_mask: got %h want 00", out_mask); end
        checks++;
        if (out_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_out_count: got %0d want 0", out_count); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_full_line();
        logic [511:0] exp;
        exp = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp[i*64 +: 64] = 64'h1000_0000_0000_0000 | 64'(i);
            drive_word(3'(i), 64'h1000_0000_0000_0000 | 64'(i), 1'b0);
            if (i == 6) begin
                checks++;
                if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_early_valid: got %b want 0", out_valid); end
            end
        end
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_valid: got %b want 1", out_valid); end
        checks++;
        if (out_mask !== 8'hFF) begin failures++; $display("[TB] FAIL full_mask: got %h want ff", out_mask); end
        checks++;
        if (out_count !== 4'd8) begin failures++; $display("[TB] FAIL full_count: got %0d want 8", out_count); end
        checks++;
        if (out_data !== exp) begin failures++; $display("[TB] FAIL full_data: got %h want %h", out_data, exp); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_valid_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_duplicate_lane();
        logic [511:0] exp;
        exp = '0;
        exp[3*64 +: 64] = 64'hCCCC_0000_0000_0003;
        exp[5*64 +: 64] = 64'hBBBB_0000_0000_0005;
        out_ready = 1'b1;
        drive_word(3'd3, 64'hAAAA_0000_0000_0003, 1'b0);
        drive_word(3'd5, 64'hBBBB_0000_0000_0005, 1'b0);
        drive_word(3'd3, 64'hCCCC_0000_0000_0003, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL dup_valid: got %b want 1", out_valid); end
        checks++;
        if (out_mask !== 8'h28) begin failures++; $display("[TB] FAIL dup_mask: got %h want 28", out_mask); end
        checks++;
        if (out_count !== 4'd2) begin failures++; $display("[TB] FAIL dup_count: got %0d want 2", out_count); end
        checks++;
        if (out_data !== exp) begin failures++; $display("[TB] FAIL dup_data: got %h want %h", out_data, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [511:0] exp;
        logic [511:0] exp2;
        exp  = '0;
        exp2 = '0;
        exp2[2*64 +: 64] = 64'hEEEE_0000_0000_0002;
        out_ready = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            exp[i*64 +: 64] = 64'h3000_0000_0000_0000 | 64'(i);
            drive_word(3'(i), 64'h3000_0000_0000_0000 | 64'(i), 1'b0);
        end
        in_valid  = 1'b1;
        in_select = 3'd0;
        in_data   = 64'hDEAD_0000_0000_0000;
        in_last   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready cyc %0d: got %b want 0", c, in_ready); end
            checks++;
            if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid cyc %0d: got %b want 1", c, out_valid); end
            checks++;
            if (out_data !== exp || out_mask !== 8'hFF || out_count !== 4'd8) begin
                failures++;
                $display("[TB] FAIL bp_stable cyc %0d: mask %h count %0d data %h want mask ff count 8 data %h", c, out_mask, out_count, out_data, exp);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_valid: got %b want 0", out_valid); end
        drive_word(3'd2, 64'hEEEE_0000_0000_0002, 1'b1);
        checks++;
        if (out_mask !== 8'h04 || out_count !== 4'd1 || out_data !== exp2) begin
            failures++;
            $display("[TB] FAIL bp_after_line: mask %h count %0d data %h want mask 04 count 1 data %h", out_mask, out_count, out_data, exp2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [511:0] exp1;
        logic [511:0] exp2;
        int lc0;
        exp1 = '0;
        exp2 = '0;
        exp1[1*64 +: 64] = 64'h4444_0000_0000_0001;
        exp2[6*64 +: 64] = 64'h4444_0000_0000_0006;
        out_ready = 1'b1;
        lc0 = line_count;
        drive_word(3'd1, 64'h4444_0000_0000_0001, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 8'h02 || out_data !== exp1) begin
            failures++;
            $display("[TB] FAIL b2b_first: valid %b mask %h data %h want valid 1 mask 02 data %h", out_valid, out_mask, out_data, exp1);
        end
        drive_word(3'd6, 64'h4444_0000_0000_0006, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 8'h40 || out_count !== 4'd1 || out_data !== exp2) begin
            failures++;
            $display("[TB] FAIL b2b_second: valid %b mask %h count %0d data %h want valid 1 mask 40 count 1 data %h", out_valid, out_mask, out_count, out_data, exp2);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain: got %b want 0", out_valid); end
        checks++;
        if (line_count - lc0 !== 2) begin failures++; $display("[TB] FAIL b2b_lines: got %0d want 2", line_count - lc0); end
    endtask

    task automatic test_reset_mid_line();
        logic [511:0] exp;
        logic [511:0] expf;
        exp  = '0;
        expf = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_word(3'(i), 64'h5000_0000_0000_0000 | 64'(i), 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_partial_valid: got %b want 0", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 512'd0 || out_mask !== 8'h00 || out_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL rst_mid_clear: valid %b mask %h count %0d data %h want all zero", out_valid, out_mask, out_count, out_data);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 4; i < 8; i++) begin
            exp[i*64 +: 64] = 64'h5100_0000_0000_0000 | 64'(i);
            drive_word(3'(i), 64'h5100_0000_0000_0000 | 64'(i), (i == 7));
        end
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 8'hF0 || out_count !== 4'd4 || out_data !== exp) begin
            failures++;
            $display("[TB] FAIL rst_no_stale: valid %b mask %h count %0d data %h want valid 1 mask f0 count 4 data %h", out_valid, out_mask, out_count, out_data, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_while_valid: valid %b ready %b want valid 0 ready 1", out_valid, in_ready);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expf[i*64 +: 64] = 64'h6000_0000_0000_0000 | 64'(i);
            drive_word(3'(i), 64'h6000_0000_0000_0000 | 64'(i), 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 8'hFF || out_count !== 4'd8 || out_data !== expf) begin
            failures++;
            $display("[TB] FAIL rst_full_after: valid %b mask %h count %0d data %h want valid 1 mask ff count 8 data %h", out_valid, out_mask, out_count, out_data, expf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream_last();
        logic [511:0] exp;
        int lc0;
        int ready_bad;
        int line_bad;
        out_ready = 1'b1;
        lc0       = line_count;
        ready_bad = 0;
        line_bad  = 0;
        for (int i = 0; i < 16; i++) begin
            exp = '0;
            exp[(i % 8)*64 +: 64] = 64'h7000_0000_0000_0000 | 64'(i);
            if (in_ready !== 1'b1) ready_bad++;
            in_valid  = 1'b1;
            in_select = 3'(i % 8);
            in_data   = 64'h7000_0000_0000_0000 | 64'(i);
            in_last   = 1'b1;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_count !== 4'd1 || out_mask !== (8'h01 << (i % 8)) || out_data !== exp) begin
                line_bad++;
                $display("[TB] line %0d: valid %b mask %h count %0d", i, out_valid, out_mask, out_count);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_bad !== 0) begin failures++; $display("[TB] FAIL stream_in_ready: %0d low cycles want 0", ready_bad); end
        checks++;
        if (line_bad !== 0) begin failures++; $display("[TB] FAIL stream_lines_content: %0d bad lines want 0", line_bad); end
        checks++;
        if (line_count - lc0 !== 16) begin failures++; $display("[TB] FAIL stream_line_count: got %0d want 16", line_count - lc0); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    // Scenario sequence.
    initial begin
        checks     = 0;
        failures   = 0;
        line_count = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_select  = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        #1;
        test_reset();
        test_full_line();
        test_duplicate_lane();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_line();
        test_stream_last();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
